// File: rtl/tlc_pkg.sv
// Shared types and encodings for the traffic-light controller and its sensor front end.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    LOCKOUT = 2'b10
  } sensor_state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRE = 3'b001;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlc_sync_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer on the loop-detector input.
module tlc_sync_debounce
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] db_cnt;

  // Stage p0/p1: metastability chain, free-running regardless of ena
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= din;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: a level change is accepted only after DEBOUNCE_CYCLES stable samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt <= '0;
      dout   <= 1'b0;
    end else if (ena) begin
      if (sync_p1 == dout) begin
        db_cnt <= '0;
      end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        dout   <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_sensor_conditioner.sv
// Farm-road car sensor front end: debounced level -> held request with post-service lockout
// and a saturating wait timer with overdue flag.
module tlc_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned LOCKOUT_CYCLES  = 8,
  parameter int unsigned WAIT_W          = 8,
  parameter int unsigned OVERDUE_CYCLES  = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              sensor_raw,
  input  logic              serve_ack,
  output logic              car_req,
  output logic              sensor_clean,
  output logic [WAIT_W-1:0] wait_cycles,
  output logic              overdue
);

  localparam int unsigned LCK_W = cnt_width(LOCKOUT_CYCLES);

  sensor_state_t     state_q, state_nxt;
  logic [LCK_W-1:0]  lock_q, lock_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  tlc_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .din (sensor_raw),
    .dout(sensor_clean)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      wait_q  <= '0;
    end else if (ena) begin
      state_q <= state_nxt;
      lock_q  <= lock_nxt;
      wait_q  <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    lock_nxt  = lock_q;
    wait_nxt  = wait_q;
    case (state_q)
      IDLE: begin
        if (sensor_clean) begin
          state_nxt = REQ;
          wait_nxt  = '0;
        end
      end
      REQ: begin
        // The ack takes priority, so the reported wait is the pre-service value.
        if (serve_ack) begin
          state_nxt = LOCKOUT;
          lock_nxt  = LCK_W'(LOCKOUT_CYCLES - 1);
        end else begin
          wait_nxt  = sat_inc(wait_q);
        end
      end
      LOCKOUT: begin
        if (lock_q == '0) state_nxt = IDLE;
        else              lock_nxt  = lock_q - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign car_req     = (state_q == REQ);
  assign wait_cycles = wait_q;
  assign overdue     = (wait_q >= WAIT_W'(OVERDUE_CYCLES));

endmodule
